// File: rtl/mem_tp_bit_wrap.sv
// Simple two-port memory with a bit-granular write port A and a registered
// read port B whose output holds its value whenever port B is not enabled.
module mem_tp_bit_wrap #(
  parameter string MEM_TYPE      = "auto",
  parameter int    MEM_DATAWIDTH = 128,
  parameter int    MEM_ADDRWIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     ena_i,
  input  logic [MEM_DATAWIDTH-1:0] wea_i,
  input  logic [MEM_ADDRWIDTH-1:0] addra_i,
  input  logic [MEM_DATAWIDTH-1:0] dina_i,
  input  logic                     enb_i,
  input  logic [MEM_ADDRWIDTH-1:0] addrb_i,
  output logic [MEM_DATAWIDTH-1:0] doutb_o
);

  localparam int DEPTH = 1 << MEM_ADDRWIDTH;

  logic [MEM_DATAWIDTH-1:0] doutb_q;

  // One branch per memory style so the synthesis attribute can stay a literal.
  if (MEM_TYPE == "block") begin : gBlock
    (* ram_style = "block" *) logic [MEM_DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (ena_i) mem[addra_i] <= (mem[addra_i] & ~wea_i) | (dina_i & wea_i);
      if (enb_i) doutb_q <= mem[addrb_i];
    end
  end else if (MEM_TYPE == "distributed") begin : gDistributed
    (* ram_style = "distributed" *) logic [MEM_DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (ena_i) mem[addra_i] <= (mem[addra_i] & ~wea_i) | (dina_i & wea_i);
      if (enb_i) doutb_q <= mem[addrb_i];
    end
  end else if (MEM_TYPE == "ultra") begin : gUltra
    (* ram_style = "ultra" *) logic [MEM_DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (ena_i) mem[addra_i] <= (mem[addra_i] & ~wea_i) | (dina_i & wea_i);
      if (enb_i) doutb_q <= mem[addrb_i];
    end
  end else begin : gAuto
    logic [MEM_DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (ena_i) mem[addra_i] <= (mem[addra_i] & ~wea_i) | (dina_i & wea_i);
      if (enb_i) doutb_q <= mem[addrb_i];
    end
  end

  assign doutb_o = doutb_q;

endmodule

// File: rtl/mem_tp_fifo.sv
// Valid/ready FIFO built on a two-port memory; the head word comes straight
// from the memory's registered read port, so rd_valid tracks that register.
module mem_tp_fifo #(
  parameter string MEM_TYPE      = "auto",
  parameter int    MEM_DATAWIDTH = 128,
  parameter int    MEM_ADDRWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [MEM_DATAWIDTH-1:0] wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [MEM_DATAWIDTH-1:0] rd_data,
  output logic [MEM_ADDRWIDTH:0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam logic [MEM_ADDRWIDTH:0] DEPTH = {1'b1, {MEM_ADDRWIDTH{1'b0}}};

  logic [MEM_ADDRWIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [MEM_ADDRWIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [MEM_ADDRWIDTH:0]   memCnt_q, memCnt_d;
  logic                     rdValid_q, rdValid_d;
  logic                     push;
  logic                     pop;
  logic                     readIssue;

  // wr_ready looks only at the stored count, so a pop while full frees a slot
  // one cycle later rather than forming a combinational path to rd_ready.
  assign wr_ready  = (memCnt_q != DEPTH) && !reset && !flush;
  assign push      = wr_valid && wr_ready;
  assign pop       = rdValid_q && rd_ready;
  assign readIssue = (memCnt_q != '0) && (!rdValid_q || rd_ready) && !reset && !flush;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    memCnt_d  = memCnt_q + (MEM_ADDRWIDTH+1)'(push) - (MEM_ADDRWIDTH+1)'(readIssue);
    rdValid_d = rdValid_q;
    if (push)      wrPtr_d = wrPtr_q + (MEM_ADDRWIDTH)'(1);
    if (readIssue) rdPtr_d = rdPtr_q + (MEM_ADDRWIDTH)'(1);
    if (readIssue)  rdValid_d = 1'b1;
    else if (pop)   rdValid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      memCnt_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      memCnt_q  <= memCnt_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rd_valid = rdValid_q;
  assign level    = memCnt_q + (MEM_ADDRWIDTH+1)'(rdValid_q);
  assign empty    = (level == '0);
  assign full     = !wr_ready;

  mem_tp_bit_wrap #(
    .MEM_TYPE      (MEM_TYPE),
    .MEM_DATAWIDTH (MEM_DATAWIDTH),
    .MEM_ADDRWIDTH (MEM_ADDRWIDTH)
  ) uMem (
    .clk_i   (clk),
    .ena_i   (push),
    .wea_i   ({MEM_DATAWIDTH{1'b1}}),
    .addra_i (wrPtr_q),
    .dina_i  (wr_data),
    .enb_i   (readIssue),
    .addrb_i (rdPtr_q),
    .doutb_o (rd_data)
  );

endmodule
